// File: rtl/split_pkg.sv
// Shared widths and tag payload for the segment tagger (split_segment_tagger).
package split_pkg;

  localparam int unsigned SEG_W   = 32;
  localparam int unsigned PN_W    = 4;
  localparam int unsigned ZN_W    = 12;
  localparam int unsigned EMPTY_W = 2;

  // Per-segment tag handed to the CRC lanes
  typedef struct packed {
    logic [PN_W-1:0] packet_num;
    logic [ZN_W-1:0] zero_num;
  } seg_tag_t;

endpackage

// File: rtl/split_tag_scan.sv
// Combinational prefix scan over one beat: packet numbering, goback distances,
// orphan masking, next open state and framing error flags.
module split_tag_scan
  import split_pkg::*;
#(
  parameter int unsigned SEG_NUM = 8
) (
  input  logic                       open_in,
  input  logic [SEG_NUM-1:0]         sop,
  input  logic [SEG_NUM-1:0]         eop,
  input  logic [SEG_NUM-1:0]         dval,
  input  logic [EMPTY_W*SEG_NUM-1:0] empty,
  output logic [SEG_NUM-1:0]         keep_c,
  output logic [PN_W*SEG_NUM-1:0]    packet_num_c,
  output logic [ZN_W*SEG_NUM-1:0]    zero_num_c,
  output logic                       open_out_c,
  output logic                       err_sop_c,
  output logic                       err_orphan_c
);

  logic [PN_W-1:0]    pn [SEG_NUM];
  seg_tag_t           tag [SEG_NUM];
  logic               run_open;
  logic               bump;
  logic [PN_W-1:0]    cnt;
  logic [ZN_W-1:0]    same;
  logic [EMPTY_W-1:0] emp;

  // Forward scan: running open bit, packet counter bumped after each boundary segment
  always_comb begin
    run_open     = open_in;
    cnt          = PN_W'(1);
    bump         = 1'b0;
    keep_c       = '0;
    err_sop_c    = 1'b0;
    err_orphan_c = 1'b0;
    for (int j = 0; j < int'(SEG_NUM); j++) begin
      pn[j] = '0;
      bump  = 1'b0;
      if (dval[j]) begin
        if (sop[j] || run_open) begin
          if (sop[j] && run_open) begin
            err_sop_c = 1'b1;
            bump      = 1'b1;
          end
          keep_c[j] = 1'b1;
          pn[j]     = cnt;
          run_open  = 1'b1;
          if (eop[j]) begin
            run_open = 1'b0;
            bump     = 1'b1;
          end
        end else begin
          err_orphan_c = 1'b1;
        end
      end
      if (bump) cnt = cnt + PN_W'(1);
    end
    open_out_c = run_open;
  end

  // Goback distance: 4 bytes per later segment of the same packet plus that packet's eop empty
  always_comb begin
    same = '0;
    emp  = '0;
    for (int j = 0; j < int'(SEG_NUM); j++) begin
      same                = '0;
      emp                 = '0;
      tag[j].packet_num   = pn[j];
      tag[j].zero_num     = '0;
      if (keep_c[j]) begin
        for (int k = 0; k < int'(SEG_NUM); k++) begin
          if (keep_c[k] && (pn[k] == pn[j])) begin
            if (k > j) same = same + ZN_W'(1);
            if (eop[k]) emp = empty[EMPTY_W*k +: EMPTY_W];
          end
        end
        tag[j].zero_num = (same << 2) + ZN_W'(emp);
      end
    end
  end

  // Flatten tags onto the output buses
  for (genvar g = 0; g < int'(SEG_NUM); g++) begin : g_flat
    assign packet_num_c[PN_W*g +: PN_W] = tag[g].packet_num;
    assign zero_num_c[ZN_W*g +: ZN_W]   = tag[g].zero_num;
  end

endmodule

// File: rtl/split_segment_tagger.sv
// Transmit-side segment tagger: 2-stage pipeline tagging each segment with
// packet_num/zero_num, tracking packet-open state across beats.
// Optional saturating error-beat counter enabled by SPLIT_ERR_CNT_EN.
module split_segment_tagger
  import split_pkg::*;
#(
  parameter int unsigned SEG_NUM = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEG_NUM-1:0]         in_sop,
  input  logic [SEG_NUM-1:0]         in_eop,
  input  logic [SEG_NUM-1:0]         in_dval,
  input  logic [EMPTY_W*SEG_NUM-1:0] in_empty,
  input  logic [SEG_W*SEG_NUM-1:0]   in_dout,
  output logic [SEG_NUM-1:0]         out_sop,
  output logic [SEG_NUM-1:0]         out_eop,
  output logic [SEG_NUM-1:0]         out_dval,
  output logic [PN_W*SEG_NUM-1:0]    out_packet_num,
  output logic [ZN_W*SEG_NUM-1:0]    out_zero_num,
  output logic [SEG_W*SEG_NUM-1:0]   out_dout,
  output logic                       err_sop,
  output logic                       err_orphan
`ifdef SPLIT_ERR_CNT_EN
  ,
  output logic [15:0]                err_cnt
`endif
);

  logic [SEG_NUM-1:0]         s1_sop;
  logic [SEG_NUM-1:0]         s1_eop;
  logic [SEG_NUM-1:0]         s1_dval;
  logic [EMPTY_W*SEG_NUM-1:0] s1_empty;
  logic [SEG_W*SEG_NUM-1:0]   s1_dout;
  logic                       open_q;

  logic [SEG_NUM-1:0]         keep_c;
  logic [PN_W*SEG_NUM-1:0]    packet_num_c;
  logic [ZN_W*SEG_NUM-1:0]    zero_num_c;
  logic [SEG_W*SEG_NUM-1:0]   dout_c;
  logic                       open_next_c;
  logic                       err_sop_c;
  logic                       err_orphan_c;

  // Stage 1: register the raw beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sop   <= '0;
      s1_eop   <= '0;
      s1_dval  <= '0;
      s1_empty <= '0;
      s1_dout  <= '0;
    end else begin
      s1_sop   <= in_sop;
      s1_eop   <= in_eop;
      s1_dval  <= in_dval;
      s1_empty <= in_empty;
      s1_dout  <= in_dout;
    end
  end

  split_tag_scan #(
    .SEG_NUM (SEG_NUM)
  ) u_scan (
    .open_in      (open_q),
    .sop          (s1_sop),
    .eop          (s1_eop),
    .dval         (s1_dval),
    .empty        (s1_empty),
    .keep_c       (keep_c),
    .packet_num_c (packet_num_c),
    .zero_num_c   (zero_num_c),
    .open_out_c   (open_next_c),
    .err_sop_c    (err_sop_c),
    .err_orphan_c (err_orphan_c)
  );

  // Zero data of dropped or idle segments
  for (genvar g = 0; g < int'(SEG_NUM); g++) begin : g_mask
    assign dout_c[SEG_W*g +: SEG_W] = keep_c[g] ? s1_dout[SEG_W*g +: SEG_W] : '0;
  end

  // Stage 2: register tags, masked controls, error pulses and the open state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sop        <= '0;
      out_eop        <= '0;
      out_dval       <= '0;
      out_packet_num <= '0;
      out_zero_num   <= '0;
      out_dout       <= '0;
      err_sop        <= 1'b0;
      err_orphan     <= 1'b0;
      open_q         <= 1'b0;
    end else begin
      out_sop        <= s1_sop & keep_c;
      out_eop        <= s1_eop & keep_c;
      out_dval       <= keep_c;
      out_packet_num <= packet_num_c;
      out_zero_num   <= zero_num_c;
      out_dout       <= dout_c;
      err_sop        <= err_sop_c;
      err_orphan     <= err_orphan_c;
      open_q         <= open_next_c;
    end
  end

`ifdef SPLIT_ERR_CNT_EN
  // Saturating count of beats carrying any framing error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((err_sop_c || err_orphan_c) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_split_segment_tagger.sv
// Directed bench for split_segment_tagger at SEG_NUM=4 (SPLIT_ERR_CNT_EN optional).
module tb_split_segment_tagger;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_sop, in_eop, in_dval;
  logic [7:0]   in_empty;
  logic [127:0] in_dout;
  logic [3:0]   out_sop, out_eop, out_dval;
  logic [15:0]  out_packet_num;
  logic [47:0]  out_zero_num;
  logic [127:0] out_dout;
  logic         err_sop, err_orphan;
`ifdef SPLIT_ERR_CNT_EN
  logic [15:0]  err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] DATA = 128'h44444444_33333333_22222222_11111111;

  always #5 clk = ~clk;

  split_segment_tagger #(.SEG_NUM(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_dval        (in_dval),
    .in_empty       (in_empty),
    .in_dout        (in_dout),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_dval       (out_dval),
    .out_packet_num (out_packet_num),
    .out_zero_num   (out_zero_num),
    .out_dout       (out_dout),
    .err_sop        (err_sop),
    .err_orphan     (err_orphan)
`ifdef SPLIT_ERR_CNT_EN
    ,
    .err_cnt        (err_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [3:0] e, input logic [3:0] v,
                       input logic [7:0] emp);
    in_sop = s; in_eop = e; in_dval = v; in_empty = emp; in_dout = DATA;
  endtask

  task automatic idle();
    in_sop = '0; in_eop = '0; in_dval = '0; in_empty = '0; in_dout = '0;
  endtask

  // One beat followed by an idle beat; its outputs are visible on return
  task automatic apply(input logic [3:0] s, input logic [3:0] e, input logic [3:0] v,
                       input logic [7:0] emp);
    drive(s, e, v, emp);
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick(); tick();
    vectors++;
    if ({out_dval, out_sop, out_eop, out_packet_num, out_zero_num, out_dout, err_sop, err_orphan} !== '0) begin
      $display("FAIL reset_idle: outputs nonzero during reset, dval=%b pn=%h", out_dval, out_packet_num);
      miscompares++;
    end
    rst = 1'b0;
    tick();
    apply(4'b0001, 4'b0000, 4'b0001, 8'h00);
    vectors++;
    if (out_dval !== 4'b0001) begin
      $display("FAIL reset_pre: out_dval=%b expected 0001", out_dval);
      miscompares++;
    end
    drive(4'b0000, 4'b0000, 4'b0011, 8'h00);
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({out_dval, out_packet_num, out_zero_num, out_dout, err_sop, err_orphan} !== '0) begin
      $display("FAIL reset_async: dval=%b pn=%h expected all zero", out_dval, out_packet_num);
      miscompares++;
    end
    #1 rst = 1'b0;
    idle();
    tick();
    vectors++;
    if (out_dval !== 4'b0000 || err_orphan !== 1'b0) begin
      $display("FAIL reset_flush: dval=%b orphan=%b expected 0000/0", out_dval, err_orphan);
      miscompares++;
    end
    apply(4'b0000, 4'b0000, 4'b0001, 8'h00);
    vectors++;
    if (err_orphan !== 1'b1 || out_dval !== 4'b0000 || out_dout !== '0) begin
      $display("FAIL reset_open: orphan=%b dval=%b expected 1/0000", err_orphan, out_dval);
      miscompares++;
    end
  endtask

  task automatic test_one_packet();
    drive(4'b0001, 4'b1000, 4'b1111, 8'h80);
    tick();
    idle();
    vectors++;
    if (out_dval !== 4'b0000) begin
      $display("FAIL latency_early: out_dval=%b expected 0000 after one cycle", out_dval);
      miscompares++;
    end
    tick();
    vectors++;
    if (out_packet_num !== 16'h1111) begin
      $display("FAIL one_pkt_pn: got %h expected 1111", out_packet_num);
      miscompares++;
    end
    vectors++;
    if (out_zero_num !== {12'd2, 12'd6, 12'd10, 12'd14}) begin
      $display("FAIL one_pkt_zn: got %h expected %h", out_zero_num, {12'd2, 12'd6, 12'd10, 12'd14});
      miscompares++;
    end
    vectors++;
    if (out_dval !== 4'b1111 || out_sop !== 4'b0001 || out_eop !== 4'b1000 ||
        out_dout !== DATA || err_sop !== 1'b0 || err_orphan !== 1'b0) begin
      $display("FAIL one_pkt_ctl: dval=%b sop=%b eop=%b errs=%b%b", out_dval, out_sop, out_eop, err_sop, err_orphan);
      miscompares++;
    end
  endtask

  task automatic test_two_packets();
    apply(4'b0101, 4'b1010, 4'b1111, 8'h00);
    vectors++;
    if (out_packet_num !== 16'h2211 || out_zero_num !== {12'd0, 12'd4, 12'd0, 12'd4}) begin
      $display("FAIL two_pkt: pn=%h zn=%h expected 2211/%h", out_packet_num, out_zero_num, {12'd0, 12'd4, 12'd0, 12'd4});
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    drive(4'b0100, 4'b0000, 4'b1111, 8'h00);
    tick();
    drive(4'b0000, 4'b0010, 4'b0011, 8'h00);
    tick();
    vectors++;
    if (out_packet_num !== 16'h1100 || out_zero_num !== {12'd0, 12'd4, 12'd0, 12'd0}) begin
      $display("FAIL cross_a_tag: pn=%h zn=%h expected 1100/%h", out_packet_num, out_zero_num, {12'd0, 12'd4, 12'd0, 12'd0});
      miscompares++;
    end
    vectors++;
    if (err_orphan !== 1'b1 || err_sop !== 1'b0 || out_dval !== 4'b1100 || out_sop !== 4'b0100 ||
        out_dout !== 128'h44444444_33333333_00000000_00000000) begin
      $display("FAIL cross_a_ctl: orphan=%b sop_err=%b dval=%b dout=%h", err_orphan, err_sop, out_dval, out_dout);
      miscompares++;
    end
    idle();
    tick();
    vectors++;
    if (out_packet_num !== 16'h0011 || out_zero_num !== {12'd0, 12'd0, 12'd0, 12'd4} ||
        err_orphan !== 1'b0 || err_sop !== 1'b0 || out_eop !== 4'b0010 || out_dval !== 4'b0011) begin
      $display("FAIL cross_b: pn=%h zn=%h errs=%b%b eop=%b", out_packet_num, out_zero_num, err_sop, err_orphan, out_eop);
      miscompares++;
    end
  endtask

  task automatic test_double_sop();
    apply(4'b0001, 4'b0000, 4'b0001, 8'h00);
    vectors++;
    if (out_packet_num !== 16'h0001 || out_zero_num !== '0 || err_sop !== 1'b0) begin
      $display("FAIL dsop_open: pn=%h zn=%h err_sop=%b", out_packet_num, out_zero_num, err_sop);
      miscompares++;
    end
    apply(4'b0001, 4'b0001, 4'b0001, 8'h01);
    vectors++;
    if (err_sop !== 1'b1 || out_packet_num !== 16'h0001 || out_zero_num !== 48'd1 || err_orphan !== 1'b0) begin
      $display("FAIL dsop_err: err_sop=%b pn=%h zn=%h expected 1/0001/1", err_sop, out_packet_num, out_zero_num);
      miscompares++;
    end
    apply(4'b0000, 4'b0000, 4'b0001, 8'h00);
    vectors++;
    if (err_orphan !== 1'b1 || out_dval !== 4'b0000) begin
      $display("FAIL dsop_closed: orphan=%b dval=%b expected 1/0000", err_orphan, out_dval);
      miscompares++;
    end
  endtask

  task automatic test_both_errors();
    apply(4'b0110, 4'b0100, 4'b0111, 8'h30);
    vectors++;
    if (err_sop !== 1'b1 || err_orphan !== 1'b1) begin
      $display("FAIL both_err: err_sop=%b err_orphan=%b expected 1/1", err_sop, err_orphan);
      miscompares++;
    end
    vectors++;
    if (out_packet_num !== 16'h0110 || out_zero_num !== {12'd0, 12'd3, 12'd7, 12'd0} || out_dval !== 4'b0110) begin
      $display("FAIL both_tag: pn=%h zn=%h dval=%b", out_packet_num, out_zero_num, out_dval);
      miscompares++;
    end
  endtask

  task automatic test_idle_beat();
    apply(4'b1111, 4'b1111, 4'b0000, 8'hFF);
    vectors++;
    if ({out_dval, out_sop, out_eop, out_packet_num, out_zero_num, out_dout, err_sop, err_orphan} !== '0) begin
      $display("FAIL idle_beat: dval=%b sop=%b dout=%h expected zero", out_dval, out_sop, out_dout);
      miscompares++;
    end
  endtask

`ifdef SPLIT_ERR_CNT_EN
  task automatic test_err_cnt();
    rst = 1'b1;
    #2 rst = 1'b0;
    idle();
    tick();
    drive(4'b0000, 4'b0000, 4'b0001, 8'h00);
    tick(); tick(); tick();
    idle();
    tick(); tick();
    vectors++;
    if (err_cnt !== 16'd3) begin
      $display("FAIL err_cnt_3: got %0d expected 3", err_cnt);
      miscompares++;
    end
    drive(4'b0000, 4'b0000, 4'b0001, 8'h00);
    repeat (65536) tick();
    idle();
    tick(); tick();
    vectors++;
    if (err_cnt !== 16'hFFFF) begin
      $display("FAIL err_cnt_sat: got %h expected ffff", err_cnt);
      miscompares++;
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_one_packet();
    test_two_packets();
    test_back_to_back();
    test_double_sop();
    test_both_errors();
    test_idle_beat();
`ifdef SPLIT_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
